maclaurin_result_collector: RTL and testbench
=============================================

// Module: maclaurin_result_collector
// PURPOSE
//  Downstream stage of the Maclaurin series pipeline; consumes each finished term sum (32-bit Q2.30 res + ov flag).
//  Rounds/saturates the sum to 16-bit Q1.15 and buffers it in a small FIFO.
//  Presents results on a valid/ready interface; the pipeline has no back-pressure, so the block counts and flags drops.
// PARAMETERS
//  DEPTH      4   FIFO entries; power of two, >= 2
//  AW         2   log2(DEPTH); pointer width
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       pipeline result present this cycle
//  in_res     in   32      signed Q2.30 series sum from last pipe stage
//  in_ov      in   1       overflow flag accumulated along the pipe
//  out_valid  out  1       head entry available
//  out_ready  in   1       consumer accepts head when out_valid=1
//  out_data   out  16      signed Q1.15 result at FIFO head
//  out_ov     out  1       head entry was saturated (in_ov or rounding overflow)
//  count      out  AW+1    entries held, 0..DEPTH
//  drop       out  1       sticky: a push was lost because FIFO was full
//  drop_cnt   out  8       lost pushes since reset, saturates at 255
//  clr_drop   in   1       clears drop and drop_cnt next edge
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_ov=0, count=0, drop=0, drop_cnt=0, pointers=0.
//  Conversion (combinational, before write):
//   - s = sext33(in_res) + 33'h0_0000_4000 (round half up at bit 14).
//   - in_ov=1 -> data = in_res[31] ? 16'h7FFF : 16'h8000; sat=1.
//   - else s[32:30] not all equal -> data = s[32] ? 16'h8000 : 16'h7FFF; sat=1.
//   - else data = s[30:15], sat=0.
//   - Stored entry = {sat, data} (17 bits).
//  Push: in_valid=1 and (count<DEPTH or pop this cycle).
//   - Write at wr_ptr; wr_ptr+1 wraps mod DEPTH.
//  Pop: out_valid=1 and out_ready=1; rd_ptr+1 wraps mod DEPTH.
//  Outputs:
//   - First-word fall-through; out_data/out_ov = entry at rd_ptr.
//   - out_valid = (count!=0), registered.
//   - Latency in_valid -> out_valid: 1 clock.
//  Simultaneous push+pop:
//   - count unchanged; allowed when full (freed slot reused same edge).
//   - When empty, no bypass: out_valid=0, so no pop; the push is stored.
//  Drop: in_valid=1, count==DEPTH, no pop.
//   - Entry discarded; drop<=1; drop_cnt+1, saturating at 255.
//   - If clr_drop and a drop coincide: drop=1, drop_cnt=1.
//  out_data/out_ov hold stable while out_valid=1 and out_ready=0.
//  Reset mid-stream discards all entries; in_valid on the reset cycle is ignored.
// TESTING
//  T1 in_res=32'h2000_0000, ov=0 -> next cycle out_valid=1, out_data=16'h4000, out_ov=0
//  T2 rounding: 32'h0000_4000 -> 16'h0001; 32'hC000_0000 -> 16'h8000;
//     32'h3FFF_C000 -> 16'h7FFF with out_ov=1
//  T3 in_ov=1, in_res=32'h8000_0000 -> out_data=16'h7FFF, out_ov=1;
//     in_res=32'h1000_0000 -> 16'h8000, out_ov=1
//  T4 out_ready=0, push 5 values -> count=4, drop=1, drop_cnt=1; drain yields the first 4 in order
//  T5 full, in_valid=1 and out_ready=1 same cycle -> count stays 4, no drop, new entry at tail;
//     empty push with out_ready=1 -> count=1
//  T6 rst asserted with count=3 -> next cycle count=0, out_valid=0;
//     clr_drop after T4 -> drop=0, drop_cnt=0

Source files
------------

// File: rtl/maclaurin_result_collector.sv
// Output stage of the Maclaurin pipeline: rounds/saturates Q2.30 sums to Q1.15 and
// buffers them in a first-word-fall-through FIFO, counting pushes lost while full.
module maclaurin_result_collector #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   in_res,
    input  logic          in_ov,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic          out_ov,
    output logic [AW:0]   count,
    output logic          drop,
    output logic [7:0]    drop_cnt,
    input  logic          clr_drop
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          drop_q, drop_d;
    logic [7:0]    dropCnt_q, dropCnt_d;

    logic [32:0]   roundSum;
    logic [15:0]   convData;
    logic          convSat;
    logic          doPush;
    logic          doPop;
    logic          dropEvent;

    // Round half up at bit 14; a sum outside Q1.15 shows up as disagreement in s[32:30].
    always_comb begin
        roundSum = {in_res[31], in_res} + 33'h0_0000_4000;
        convData = roundSum[30:15];
        convSat  = 1'b0;
        if (in_ov) begin
            convData = in_res[31] ? 16'h7FFF : 16'h8000;
            convSat  = 1'b1;
        end else if (!((roundSum[32:30] == 3'b000) || (roundSum[32:30] == 3'b111))) begin
            convData = roundSum[32] ? 16'h8000 : 16'h7FFF;
            convSat  = 1'b1;
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        doPop     = (count_q != '0) && out_ready;
        doPush    = in_valid && ((count_q != FULL_COUNT) || doPop);
        dropEvent = in_valid && (count_q == FULL_COUNT) && !doPop;

        wrPtr_d   = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d   = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d   = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end

        drop_d    = drop_q;
        dropCnt_d = dropCnt_q;
        if (dropEvent) begin
            drop_d    = 1'b1;
            dropCnt_d = clr_drop ? 8'd1 : ((dropCnt_q == 8'hFF) ? 8'hFF : dropCnt_q + 8'd1);
        end else if (clr_drop) begin
            drop_d    = 1'b0;
            dropCnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
            dropCnt_q <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            dropCnt_q <= dropCnt_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= {convSat, convData};
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rdPtr_q][15:0];
    assign out_ov    = mem_q[rdPtr_q][16];
    assign count     = count_q;
    assign drop      = drop_q;
    assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_maclaurin_result_collector.sv
// Self-checking bench for maclaurin_result_collector: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_maclaurin_result_collector;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [31:0]   in_res = '0;
    logic          in_ov = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_data;
    logic          out_ov;
    logic [AW:0]   count;
    logic          drop;
    logic [7:0]    drop_cnt;
    logic          clr_drop = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [16:0] mq[$];
    int          mDrop = 0;
    int          mCnt  = 0;

    maclaurin_result_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_res(in_res), .in_ov(in_ov),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ov(out_ov),
        .count(count), .drop(drop), .drop_cnt(drop_cnt), .clr_drop(clr_drop)
    );

    always #5 clk = ~clk;

    // Reference conversion using signed arithmetic: floor((v + 2^14) / 2^15), then clamp.
    function automatic logic [16:0] refConvert(input logic [31:0] r, input bit o);
        longint v;
        longint q;
        logic [16:0] res;
        v = longint'($signed(r));
        if (o) begin
            res = {1'b1, (v < 0) ? 16'h7FFF : 16'h8000};
        end else begin
            q = (v + 64'sd16384) >>> 15;
            if (q > 32767)       res = {1'b1, 16'h7FFF};
            else if (q < -32768) res = {1'b1, 16'h8000};
            else                 res = {1'b0, 16'(q)};
        end
        return res;
    endfunction

    // Drives one clock of stimulus and advances the reference model across that edge.
    task automatic cycle(input bit v, input logic [31:0] r, input bit o,
                         input bit rdy, input bit clr, input bit rs);
        bit popNow;
        bit fullNow;
        in_valid = v; in_res = r; in_ov = o; out_ready = rdy; clr_drop = clr; rst = rs;
        if (rs) begin
            mq.delete();
            mDrop = 0;
            mCnt  = 0;
        end else begin
            popNow  = (mq.size() > 0) && rdy;
            fullNow = (mq.size() == DEPTH);
            if (popNow) void'(mq.pop_front());
            if (v && fullNow && !popNow) begin
                mDrop = 1;
                mCnt  = clr ? 1 : ((mCnt == 255) ? 255 : mCnt + 1);
            end else begin
                if (v) mq.push_back(refConvert(r, o));
                if (clr) begin
                    mDrop = 0;
                    mCnt  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", out_valid); end
        if (out_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0000", out_data); end
        if (out_ov !== 1'b0)    begin errors++; $display("[TB] FAIL reset_ov got %b exp 0", out_ov); end
        if (count !== '0)       begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
        if (drop !== 1'b0)      begin errors++; $display("[TB] FAIL reset_drop got %b exp 0", drop); end
        if (drop_cnt !== 8'h0)  begin errors++; $display("[TB] FAIL reset_dropcnt got %0d exp 0", drop_cnt); end
        idle();
    endtask

    task automatic test_conversion();
        logic [31:0] tRes [6] = '{32'h2000_0000, 32'h0000_4000, 32'hC000_0000,
                                  32'h3FFF_C000, 32'h8000_0000, 32'h1000_0000};
        bit          tOv  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] tData[6] = '{16'h4000, 16'h0001, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000};
        bit          tSat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, tRes[i], tOv[i], 1'b0, 1'b0, 1'b0);
            checks += 4;
            if (out_valid !== 1'b1)  begin errors++; $display("[TB] FAIL conv_valid[%0d] got %b exp 1", i, out_valid); end
            if (out_data !== tData[i]) begin errors++; $display("[TB] FAIL conv_data[%0d] got %h exp %h", i, out_data, tData[i]); end
            if (out_ov !== tSat[i])  begin errors++; $display("[TB] FAIL conv_ov[%0d] got %b exp %b", i, out_ov, tSat[i]); end
            if (count !== 3'd1)      begin errors++; $display("[TB] FAIL conv_count[%0d] got %0d exp 1", i, count); end
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (count !== 3'd0) begin errors++; $display("[TB] FAIL conv_pop[%0d] got %0d exp 0", i, count); end
        end
    endtask

    task automatic test_overflow();
        logic [16:0] exp[5];
        logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            exp[i] = refConvert(r, 1'b0);
            cycle(1'b1, r, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks += 3;
        if (count !== 3'd4)    begin errors++; $display("[TB] FAIL ovf_count got %0d exp 4", count); end
        if (drop !== 1'b1)     begin errors++; $display("[TB] FAIL ovf_drop got %b exp 1", drop); end
        if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL ovf_dropcnt got %0d exp 1", drop_cnt); end
        // Hold with ready low: head must stay put.
        idle();
        checks++;
        if (out_data !== exp[0][15:0]) begin errors++; $display("[TB] FAIL ovf_hold got %h exp %h", out_data, exp[0][15:0]); end
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (out_data !== exp[i][15:0]) begin errors++; $display("[TB] FAIL ovf_order[%0d] got %h exp %h", i, out_data, exp[i][15:0]); end
            if (out_ov !== exp[i][16])     begin errors++; $display("[TB] FAIL ovf_order_ov[%0d] got %b exp %b", i, out_ov, exp[i][16]); end
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_clear_drop();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks += 2;
        if (drop !== 1'b0)     begin errors++; $display("[TB] FAIL clr_drop got %b exp 0", drop); end
        if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL clr_dropcnt got %0d exp 0", drop_cnt); end
        for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (drop_cnt !== 8'd2) begin errors++; $display("[TB] FAIL clr_pre got %0d exp 2", drop_cnt); end
        cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
        checks += 2;
        if (drop !== 1'b1)     begin errors++; $display("[TB] FAIL clr_coincide_drop got %b exp 1", drop); end
        if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL clr_coincide_cnt got %0d exp 1", drop_cnt); end
        for (int i = 0; i < 258; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL drop_saturate got %0d exp 255", drop_cnt); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp[6];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            exp[i] = refConvert(r, 1'b0);
            cycle(1'b1, r, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        r = $urandom;
        exp[4] = refConvert(r, 1'b0);
        cycle(1'b1, r, 1'b0, 1'b1, 1'b0, 1'b0);
        checks += 3;
        if (count !== 3'd4)            begin errors++; $display("[TB] FAIL b2b_count got %0d exp 4", count); end
        if (drop !== 1'b0)             begin errors++; $display("[TB] FAIL b2b_drop got %b exp 0", drop); end
        if (out_data !== exp[1][15:0]) begin errors++; $display("[TB] FAIL b2b_head got %h exp %h", out_data, exp[1][15:0]); end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (out_data !== exp[i][15:0]) begin errors++; $display("[TB] FAIL b2b_order[%0d] got %h exp %h", i, out_data, exp[i][15:0]); end
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        r = $urandom;
        exp[5] = refConvert(r, 1'b0);
        cycle(1'b1, r, 1'b0, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (count !== 3'd1)            begin errors++; $display("[TB] FAIL b2b_emptypush got %0d exp 1", count); end
        if (out_data !== exp[5][15:0]) begin errors++; $display("[TB] FAIL b2b_emptydata got %h exp %h", out_data, exp[5][15:0]); end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd3) begin errors++; $display("[TB] FAIL rstmid_pre got %0d exp 3", count); end
        cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        checks += 2;
        if (count !== 3'd0)     begin errors++; $display("[TB] FAIL rstmid_count got %0d exp 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b exp 0", out_valid); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] r;
        bit v, o, rdy, clr, rs;
        for (int t = 0; t < 600; t++) begin
            case ($urandom_range(0, 3))
                0: r = $urandom;
                1: r = 32'h3FFF_8000 + $urandom_range(0, 32'h8000);
                2: r = 32'hC000_0000 - $urandom_range(0, 32'h8000);
                default: r = $urandom_range(0, 32'h0001_0000) - 32'h0000_8000;
            endcase
            v   = ($urandom_range(0, 3) != 0);
            o   = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 31) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            cycle(v, r, o, rdy, clr, rs);
            checks += 4;
            if (count !== (AW + 1)'(mq.size())) begin errors++; $display("[TB] FAIL rnd_count t=%0d got %0d exp %0d", t, count, mq.size()); end
            if (out_valid !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid t=%0d got %b exp %b", t, out_valid, mq.size() != 0); end
            if (drop !== 1'(mDrop))              begin errors++; $display("[TB] FAIL rnd_drop t=%0d got %b exp %0d", t, drop, mDrop); end
            if (drop_cnt !== 8'(mCnt))           begin errors++; $display("[TB] FAIL rnd_dropcnt t=%0d got %0d exp %0d", t, drop_cnt, mCnt); end
            if (mq.size() != 0) begin
                checks += 2;
                if (out_data !== mq[0][15:0]) begin errors++; $display("[TB] FAIL rnd_data t=%0d got %h exp %h", t, out_data, mq[0][15:0]); end
                if (out_ov !== mq[0][16])     begin errors++; $display("[TB] FAIL rnd_ov t=%0d got %b exp %b", t, out_ov, mq[0][16]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_overflow();
        test_clear_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
